nap_time_counter: RTL
=====================

# nap_time_counter

Downstream consumer of the `enable_time` field-select FSM in the nap timer.
- Edit phase: accepts keypad digits into the HH:MM:SS field selected by `hour_en`/`min_en`/`sec_en`, as BCD.
- Start: on the rising edge of `completeSetting`, loads the set duration and counts it down once per tick.
- End: raises `alarm` at 00:00:00 until acknowledged.

## Interface
- `TICK_DIV`, default 1000: clock cycles per one-second countdown tick (≥2).
- `ALARM_SECS`, default 60: alarm auto-clear time in ticks; used only with `NAP_ALARM_TIMEOUT_EN`.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `key_valid` in 1: one-cycle pulse; `key_digit` is valid.
- `key_digit` in 4: BCD digit; values 10–15 ignored.
- `hour_en` in 1: hour field selected for edit.
- `min_en` in 1: minute field selected for edit.
- `sec_en` in 1: second field selected for edit.
- `completeSetting` in 1: level; its rising edge starts the countdown.
- `alarm_ack` in 1: one-cycle pulse; clears the alarm.
- `hour_bcd` out 8: hours, two BCD digits, 00–23.
- `min_bcd` out 8: minutes, 00–59.
- `sec_bcd` out 8: seconds, 00–59.
- `running` out 1: countdown active.
- `alarm` out 1: duration expired.

## Operation
States: EDIT, RUN, ALARM.
- **EDIT:**
  - On `key_valid` with digit ≤9, the selected field shifts left: `{field[3:0], digit}`.
  - Field select priority: `sec_en` > `min_en` > `hour_en`. No enable high means the digit is ignored.
  - Range check after the shift: hour >23, or min/sec >59, makes the field `{4'h0, digit}` (e.g. min 07 then 8 gives 08).
- **EDIT → RUN:** on a `completeSetting` rising edge (registered previous value) with a nonzero total. Prescaler cleared; `running`=1.
- **EDIT → ALARM:** on a rising edge with total 00:00:00. `alarm`=1; `running` stays 0.
- **RUN:**
  - Digits and enables ignored.
  - Prescaler counts 0..TICK_DIV-1; a tick occurs when it equals TICK_DIV-1, then it wraps to 0.
  - Tick decrements in BCD with borrow:
    - sec x0 → (x-1)9;
    - sec 00 → 59 with borrow to min;
    - min 00 → 59 with borrow to hour.
  - A decrement that yields 00:00:00 goes to ALARM on that same edge: `running`=0, `alarm`=1.
- **ALARM:**
  - Fields hold 00:00:00.
  - `alarm_ack` returns to EDIT with `alarm`=0 and fields 00.
  - Digits ignored.
- Further `completeSetting` edges are ignored outside EDIT.

## Timing
- Reset values:
  - `hour_bcd`/`min_bcd`/`sec_bcd` = 8'h00; `running`=0; `alarm`=0; state EDIT; prescaler 0.
  - The previous-`completeSetting` register resets to 1, so a level already high at reset release does not start a run; a low→high transition is required.
- Digit entry: field updates on the edge that samples `key_valid`; visible the next cycle.
- Start: `running` rises on the edge that first samples `completeSetting`=1 after a sampled 0.
- First decrement occurs TICK_DIV cycles after `running` rises; subsequent ones every TICK_DIV cycles.
- Alarm: asserted on the same edge the fields reach 00:00:00.
- `alarm_ack` outside ALARM has no effect.
- `reset` has priority over everything in any state, including mid-run or mid-alarm.
- Simultaneous `alarm_ack` and timeout expiry: result is EDIT (identical outcome).

## Configuration
- **`NAP_ALARM_TIMEOUT_EN` defined:**
  - ALARM runs its own prescaler/counter; after ALARM_SECS ticks with no ack it returns to EDIT, same as ack.
  - `alarm_ack` still clears the alarm immediately.
- **Not defined:** `alarm` holds until `alarm_ack` or reset; ALARM_SECS is unused.

## Test plan
- **Field entry:** `hour_en`=1, digits 1,2 → `hour_bcd`=8'h12. Then `min_en`=1, digits 7,8 → `min_bcd`=8'h08 (78 rejected). Then `sec_en`=1, digit 11 → `sec_bcd` unchanged.
- **Enable priority:** `min_en`=`sec_en`=1, digit 5 → `sec_bcd`=8'h05, `min_bcd` unchanged.
- **Borrow:** TICK_DIV=4, set 01:00:00, raise `completeSetting` → `running`=1 next cycle. After 4 cycles → 00:59:59; after 8 → 00:59:58.
- **Expiry:** TICK_DIV=4, set 00:00:02, start → `alarm`=1 exactly 8 cycles after `running` rose, same edge as 00:00:00. `alarm_ack` pulse → `alarm`=0, state EDIT.
- **Zero start and reset release:**
  - All fields 00, rising `completeSetting` → `alarm`=1 next cycle, `running` never 1.
  - `completeSetting` held high through reset release → no start.
- **Reset mid-run and timeout:**
  - Reset asserted at 00:30:15 → next cycle all fields 00, `running`=0, `alarm`=0.
  - With `NAP_ALARM_TIMEOUT_EN`, ALARM_SECS=3, TICK_DIV=4, no ack → `alarm` clears 12 cycles after assertion.

Source files
------------

// File: rtl/nap_time_counter.sv
// nap_time_counter: HH:MM:SS BCD nap timer.
// Digits are keyed into the field chosen by the edit-select enables. A rising
// edge of completeSetting starts a once-per-tick BCD countdown. The alarm is
// raised at 00:00:00 and held until it is acknowledged.
// Optional feature macro: NAP_ALARM_TIMEOUT_EN. When it is defined, an
// unacknowledged alarm clears itself after ALARM_SECS ticks.
module nap_time_counter #(
  parameter int unsigned TICK_DIV   = 1000,
  parameter int unsigned ALARM_SECS = 60
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       hour_en,
  input  logic       min_en,
  input  logic       sec_en,
  input  logic       completeSetting,
  input  logic       alarm_ack,
  output logic [7:0] hour_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       alarm
);

  typedef enum logic [1:0] {
    S_EDIT  = 2'd0,
    S_RUN   = 2'd1,
    S_ALARM = 2'd2
  } state_t;

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

`ifdef NAP_ALARM_TIMEOUT_EN
  localparam int unsigned ACNT_W = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
  localparam logic [ACNT_W-1:0] ACNT_LAST = ACNT_W'(ALARM_SECS - 1);
  logic [ACNT_W-1:0] alarm_cnt_q;
`else
  // ALARM_SECS only matters when the self-clearing alarm is built in.
  logic unused_alarm_secs;
  assign unused_alarm_secs = (ALARM_SECS != 0);
`endif

  state_t             state_q;
  logic [7:0]         hour_q, min_q, sec_q;
  logic [PRESC_W-1:0] presc_q;
  logic               cs_prev_q;
  logic               running_q, alarm_q;

  // Two-digit BCD decrement; 00 wraps to the supplied value.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] wrap);
    logic [7:0] r;
    if (v[3:0] != 4'h0)      r = {v[7:4], v[3:0] - 4'd1};
    else if (v[7:4] != 4'h0) r = {v[7:4] - 4'd1, 4'h9};
    else                     r = wrap;
    return r;
  endfunction

  logic       digit_ok, start_edge, tick, total_zero;
  logic       sel_sec, sel_min, sel_hour;
  logic [7:0] hour_shift, min_shift, sec_shift;
  logic [7:0] hour_entry, min_entry, sec_entry;
  logic       sec_borrow, min_borrow;
  logic [7:0] hour_dec, min_dec, sec_dec;
  logic       dec_zero;

  assign digit_ok   = (key_digit <= 4'd9);
  assign start_edge = completeSetting & ~cs_prev_q;
  assign tick       = (presc_q == PRESC_LAST);
  assign total_zero = (hour_q == 8'h00) && (min_q == 8'h00) && (sec_q == 8'h00);

  // The seconds enable wins over minutes, and minutes win over hours.
  assign sel_sec  = sec_en;
  assign sel_min  = min_en & ~sec_en;
  assign sel_hour = hour_en & ~min_en & ~sec_en;

  // Shift the new digit in. An out-of-range result keeps only the new digit.
  assign hour_shift = {hour_q[3:0], key_digit};
  assign min_shift  = {min_q[3:0], key_digit};
  assign sec_shift  = {sec_q[3:0], key_digit};
  assign hour_entry = (hour_shift > 8'h23) ? {4'h0, key_digit} : hour_shift;
  assign min_entry  = (min_shift  > 8'h59) ? {4'h0, key_digit} : min_shift;
  assign sec_entry  = (sec_shift  > 8'h59) ? {4'h0, key_digit} : sec_shift;

  // Countdown with borrow: seconds -> minutes -> hours.
  assign sec_borrow = (sec_q == 8'h00);
  assign min_borrow = sec_borrow && (min_q == 8'h00);
  assign sec_dec    = bcd_dec(sec_q, 8'h59);
  assign min_dec    = sec_borrow ? bcd_dec(min_q, 8'h59) : min_q;
  assign hour_dec   = min_borrow ? bcd_dec(hour_q, 8'h00) : hour_q;
  assign dec_zero   = (hour_dec == 8'h00) && (min_dec == 8'h00) && (sec_dec == 8'h00);

  // Main controller: EDIT / RUN / ALARM with registered fields and flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_EDIT;
      hour_q    <= 8'h00;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      presc_q   <= '0;
      cs_prev_q <= 1'b1;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
`ifdef NAP_ALARM_TIMEOUT_EN
      alarm_cnt_q <= '0;
`endif
    end else begin
      cs_prev_q <= completeSetting;
      case (state_q)
        S_EDIT: begin
          if (start_edge) begin
            presc_q <= '0;
`ifdef NAP_ALARM_TIMEOUT_EN
            alarm_cnt_q <= '0;
`endif
            if (total_zero) begin
              state_q <= S_ALARM;
              alarm_q <= 1'b1;
            end else begin
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end else if (key_valid && digit_ok) begin
            if (sel_sec)       sec_q  <= sec_entry;
            else if (sel_min)  min_q  <= min_entry;
            else if (sel_hour) hour_q <= hour_entry;
          end
        end

        S_RUN: begin
          if (tick) begin
            presc_q <= '0;
            hour_q  <= hour_dec;
            min_q   <= min_dec;
            sec_q   <= sec_dec;
            if (dec_zero) begin
              state_q   <= S_ALARM;
              running_q <= 1'b0;
              alarm_q   <= 1'b1;
`ifdef NAP_ALARM_TIMEOUT_EN
              alarm_cnt_q <= '0;
`endif
            end
          end else begin
            presc_q <= presc_q + PRESC_W'(1);
          end
        end

        S_ALARM: begin
          if (alarm_ack) begin
            state_q <= S_EDIT;
            alarm_q <= 1'b0;
            hour_q  <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            presc_q <= '0;
          end
`ifdef NAP_ALARM_TIMEOUT_EN
          else if (tick) begin
            presc_q <= '0;
            if (alarm_cnt_q == ACNT_LAST) begin
              state_q <= S_EDIT;
              alarm_q <= 1'b0;
              hour_q  <= 8'h00;
              min_q   <= 8'h00;
              sec_q   <= 8'h00;
            end else begin
              alarm_cnt_q <= alarm_cnt_q + ACNT_W'(1);
            end
          end else begin
            presc_q <= presc_q + PRESC_W'(1);
          end
`endif
        end

        default: begin
          state_q   <= S_EDIT;
          running_q <= 1'b0;
          alarm_q   <= 1'b0;
        end
      endcase
    end
  end

  assign hour_bcd = hour_q;
  assign min_bcd  = min_q;
  assign sec_bcd  = sec_q;
  assign running  = running_q;
  assign alarm    = alarm_q;

endmodule
